// File: rtl/shift_seq_pkg.sv
// Purpose: shared encodings for the shift command sequencer (ops, register select, FSM states).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_seq_pkg;

  // Command opcodes; 5..7 are accepted and complete as no-ops.
  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_SHR  = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_ROR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;

  // Universal shift register select encodings.
  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // True for the four ops that step the register (shift or rotate).
  function automatic logic is_step_op(input logic [2:0] op);
    return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/shift_step_counter.sv
// Purpose: step down-counter for multi-step shift commands; last flags the final step.
// Latency: load/dec take effect at the next rising edge; last is decoded from the count.
// Backpressure: none; the caller only decrements while stepping.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        load load_val (has priority over dec)
//   load_val    step count of the accepted command
//   dec         decrement by one
//   last        count == 1, i.e. the step in progress is the final one
module shift_step_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      // Zero guard keeps the counter from wrapping if dec is ever held past the end.
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Purpose: command front-end for a universal shift register (load / n-step shift / rotate).
// Latency: LOAD done 2 cycles after accept cycle; shift of n steps done n+1 cycles after it.
// Backpressure: cmd_ready only in IDLE; a held cmd_valid waits until the current command ends.
//
// Ports:
//   cmd_valid/cmd_ready      command handshake
//   cmd_op/data/count/fill   opcode, load value, step count, shift fill bit
//   reg_q                    register output, fed back onto p_din while stepping
//   select/p_din/s_*_din     register controls
//   busy                     command in progress
//   done                     one-cycle pulse, reg_q holds the result
module shift_cmd_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] reg_q,
  output logic [1:0]       select,
  output logic [WIDTH-1:0] p_din,
  output logic             s_left_din,
  output logic             s_right_din,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic             fill_q;
  logic             accept;
  logic             last_step;

  assign accept = cmd_valid && cmd_ready;

  shift_step_counter #(.CNT_W(CNT_W)) u_step_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (cmd_count),
    .dec      (state_q == ST_SHIFT),
    .last     (last_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      data_q  <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
        fill_q <= cmd_fill;
      end
    end
  end

  // Next state. A zero-step shift and any NOP go straight to DONE, which is
  // also what keeps the step counter from ever being asked to count below 1.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_op == OP_LOAD) begin
            state_d = ST_LOAD;
          end else if (is_step_op(cmd_op) && (cmd_count != '0)) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LOAD:  state_d = ST_DONE;
      ST_SHIFT: if (last_step) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode. The register shifts p_din rather than its own output, so
  // every step drives reg_q back onto p_din; rotates also take the wrap bit
  // from reg_q. Those are the only combinational input-to-output paths.
  always_comb begin
    select      = SEL_HOLD;
    p_din       = '0;
    s_left_din  = 1'b0;
    s_right_din = 1'b0;
    case (state_q)
      ST_LOAD: begin
        select = SEL_LOAD;
        p_din  = data_q;
      end
      ST_SHIFT: begin
        p_din = reg_q;
        case (op_q)
          OP_SHR: begin
            select      = SEL_SHR;
            s_right_din = fill_q;
          end
          OP_SHL: begin
            select     = SEL_SHL;
            s_left_din = fill_q;
          end
          OP_ROR: begin
            select      = SEL_SHR;
            s_right_din = reg_q[0];
          end
          OP_ROL: begin
            select     = SEL_SHL;
            s_left_din = reg_q[WIDTH-1];
          end
          default: select = SEL_HOLD;
        endcase
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule
